random_access_memory: RTL

16-word × 8-bit RAM addressed by the memory address register's 4-bit `address` output. In run mode it sits on the shared bus: it stores the bus value at the addressed word when commanded and drives the addressed word onto the bus when commanded. In manual (programming) mode, bus traffic is ignored. The operator instead writes the word selected by the MAR's manual address switches, using 8 data switches and a debounced write push-button.

---
 rtl/random_access_memory.sv | 102 ++++++++++
 1 files changed

// File: rtl/random_access_memory.sv
// 16 x 8 RAM on the shared bus, with a debounced manual programming path.
// Reads are combinational; run-mode and manual writes are split by manual_mode.
module random_access_memory #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       read_from_bus,
    input  logic       write_to_bus,
    input  logic       manual_mode,
    input  logic [7:0] manual_switches,
    input  logic       manual_write_button,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic [7:0] contents,
    output logic       manual_write_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        strobe_q, strobe_d;

    always_comb begin
        mem_d    = mem_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        sync1_d  = manual_write_button;
        sync2_d  = sync1_q;

        case (state_q)
            ST_IDLE: begin
                if (manual_mode && sync2_q) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!sync2_q || !manual_mode) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_d[address] = manual_switches;
                    strobe_d       = 1'b1;
                    state_d        = ST_HELD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HELD: begin
                // One write per press: wait for release even if the mode changes.
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (read_from_bus && !manual_mode) begin
            mem_d[address] = bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign contents            = mem_q[address];
    assign bus_out             = (write_to_bus && !manual_mode) ? mem_q[address] : 8'h00;
    assign manual_write_strobe = strobe_q;

endmodule
